mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single-port synchronous RAM (`ramlpm`, one-cycle read latency) between the instruction fetch unit and the processor's load/store port. It grants at most one memory access per cycle and drives the RAM address, write-data and write-enable lines. One cycle after each grant it returns read data, or a write acknowledge, to the granted requester. It sits between `ifetch`/`proc` and `ramlpm` in the processor top level, replacing their separate memory paths.

## Interface
- ADDR_W, 5, memory word-address width
- DATA_W, 16, data width
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced (guard build only)

- Clock  in  1  single system clock, rising edge
- Reset  in  1  asynchronous, active-high
- fReq  in  1  fetch read request; held until granted
- fAddr  in  ADDR_W  fetch address
- fGnt  out  1  fetch request accepted this cycle
- fValid  out  1  fData valid (one cycle after fGnt)
- fData  out  DATA_W  fetched word
- dReq  in  1  data request; held until granted
- dWe  in  1  1 = write, 0 = read
- dAddr  in  ADDR_W  data address
- dWData  in  DATA_W  store data
- dGnt  out  1  data request accepted this cycle
- dValid  out  1  read data valid or write acknowledge (one cycle after dGnt)
- dRData  out  DATA_W  load data
- memAddr  out  ADDR_W  RAM address
- memDin  out  DATA_W  RAM write data
- memWe  out  1  RAM write enable
- memDout  in  DATA_W  RAM read data (valid the cycle after address sampled)

## Operation
- FSM states: READY (grant allowed) and RECOVER (no grant).
- READY with a request present: grant exactly one requester, combinationally in the same cycle.
  - Route that requester's address to memAddr, and dWData/dWe to memDin/memWe for data grants.
  - Register tag (FETCH/DATA/NONE) and isWrite.
- Default priority: data over fetch.
- Granted write: next state RECOVER for one cycle, then READY. This avoids read-during-write on the same port.
- Granted read: stays in READY, so back-to-back reads issue every cycle.
- Cycle after grant:
  - tag=FETCH: fValid=1, fData=memDout.
  - tag=DATA: dValid=1; dRData=memDout on a read, dRData=0 on a write.
  - Non-valid data outputs drive 0.
- No grant: memAddr=0, memDin=0, memWe=0.
- A request is accepted only in the cycle its Gnt is high. The requester may change address/data from the next cycle onward.
- Reset: state READY, tag NONE, starve counter 0. All outputs 0. A pending valid is discarded, even if reset arrives mid-access.

## Timing
- Read latency: grant in cycle G, data/valid in G+1.
- Write: memWe high in G, dValid in G+1, no grant in G+1 (RECOVER), next grant earliest in G+2.
- Sustained throughput: 1 read/cycle; writes 1 per 2 cycles.
- Simultaneous fReq and dReq in READY: one grant only. The loser sees Gnt=0 and keeps requesting.
- Requests arriving during RECOVER are held and evaluated in the next READY cycle.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A saturating counter increments each READY cycle in which fReq=1 and fGnt=0, and clears on fGnt.
  - When count == STARVE_MAX, fetch gets priority over data for the next grant.
- ARB_STARVE_GUARD_EN undefined:
  - Strict data-over-fetch priority. No counter. STARVE_MAX is ignored.

## Structure
- Package `mem_arb_pkg`: state enum (READY, RECOVER), tag enum (NONE, FETCH, DATA), default STARVE_MAX.
- Sub-module `arb_starve_ctr` (counter plus force flag), instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- Reset then idle: every output is 0. Assert Reset mid-read: no fValid follows.
- fReq only, fAddr=3, memory[3]=16'h1234: fGnt in C0; fValid=1 and fData=16'h1234 in C1.
- fReq and dReq read together, dAddr=7: dGnt in C0, fGnt in C1; dValid C1, fValid C2.
- dReq write addr 5 data 16'hBEEF, then data read addr 5: memWe in C0, no grant in C1, read granted C2, dRData=16'hBEEF in C3.
- fReq held with dReq reads every cycle, guard on, STARVE_MAX=4: fGnt in cycle 5. Guard off: fGnt never while dReq is held.
- Back-to-back fetch reads at addrs 0..3: one fGnt per cycle; fValid in four consecutive cycles with data in order.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory arbiter.
// Defines the arbiter FSM states, the response tag carried into the
// cycle after a grant, and the default fetch-starvation threshold.
package mem_arb_pkg;

  typedef enum logic {
    READY   = 1'b0,
    RECOVER = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_tag_t;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: counts consecutive READY cycles in which a fetch
// request was denied, saturating at STARVE_MAX. forceFetch is raised
// once the count reaches STARVE_MAX so the next grant goes to fetch.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic inc,
  input  logic clr,
  output logic forceFetch
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] count;

  // Saturating denial counter, cleared whenever fetch is granted.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign forceFetch = (count == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM (one-cycle read
// latency) between the instruction fetch port and the load/store port.
// At most one access is granted per cycle, combinationally; the response
// (read data or write acknowledge) returns one cycle after the grant.
// A granted write is followed by one RECOVER cycle with no grant.
// Build option: define ARB_STARVE_GUARD_EN to enable the fetch starvation
// guard (fetch wins the next grant after STARVE_MAX consecutive denials).
// Without it, data strictly has priority over fetch.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              fReq,
  input  logic [ADDR_W-1:0] fAddr,
  output logic              fGnt,
  output logic              fValid,
  output logic [DATA_W-1:0] fData,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWData,
  output logic              dGnt,
  output logic              dValid,
  output logic [DATA_W-1:0] dRData,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDin,
  output logic              memWe,
  input  logic [DATA_W-1:0] memDout
);

  // A threshold below one would force fetch permanently.
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be at least 1");
  end

  arb_state_t state_p0, stateNext;
  arb_tag_t   tag_p1,   tagNext;
  logic       isWrite_p1, isWriteNext;
  logic       forceFetch;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .Clock      (Clock),
    .Reset      (Reset),
    .inc        ((state_p0 == READY) && fReq && !fGnt),
    .clr        (fGnt),
    .forceFetch (forceFetch)
  );
`else
  assign forceFetch = 1'b0;
`endif

  // Grant selection, RAM port steering and next-state decode.
  always_comb begin
    stateNext   = state_p0;
    tagNext     = NONE;
    isWriteNext = 1'b0;
    fGnt        = 1'b0;
    dGnt        = 1'b0;
    memAddr     = '0;
    memDin      = '0;
    memWe       = 1'b0;
    if (state_p0 == RECOVER) begin
      stateNext = READY;
    end else if (!Reset) begin
      if (dReq && !(forceFetch && fReq)) begin
        dGnt        = 1'b1;
        memAddr     = dAddr;
        memDin      = dWData;
        memWe       = dWe;
        tagNext     = DATA;
        isWriteNext = dWe;
        if (dWe) begin
          stateNext = RECOVER;
        end
      end else if (fReq) begin
        fGnt    = 1'b1;
        memAddr = fAddr;
        tagNext = FETCH;
      end
    end
  end

  // State register and response tag for the cycle after a grant.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_p0   <= READY;
      tag_p1     <= NONE;
      isWrite_p1 <= 1'b0;
    end else begin
      state_p0   <= stateNext;
      tag_p1     <= tagNext;
      isWrite_p1 <= isWriteNext;
    end
  end

  // Response stage: RAM output is routed to whichever port was granted.
  assign fValid = (tag_p1 == FETCH);
  assign fData  = fValid ? memDout : '0;
  assign dValid = (tag_p1 == DATA);
  assign dRData = (dValid && !isWrite_p1) ? memDout : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural
// one-cycle-latency RAM attached to the arbiter's memory port.
module tb_mem_arbiter;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic        fReq;
  logic [4:0]  fAddr;
  logic        fGnt;
  logic        fValid;
  logic [15:0] fData;
  logic        dReq;
  logic        dWe;
  logic [4:0]  dAddr;
  logic [15:0] dWData;
  logic        dGnt;
  logic        dValid;
  logic [15:0] dRData;
  logic [4:0]  memAddr;
  logic [15:0] memDin;
  logic        memWe;
  logic [15:0] memDout;

  logic [15:0] mem [0:31];

  int tests = 0;
  int fails = 0;
  bit fetched;

  mem_arbiter dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .fReq    (fReq),
    .fAddr   (fAddr),
    .fGnt    (fGnt),
    .fValid  (fValid),
    .fData   (fData),
    .dReq    (dReq),
    .dWe     (dWe),
    .dAddr   (dAddr),
    .dWData  (dWData),
    .dGnt    (dGnt),
    .dValid  (dValid),
    .dRData  (dRData),
    .memAddr (memAddr),
    .memDin  (memDin),
    .memWe   (memWe),
    .memDout (memDout)
  );

  always #5 Clock = ~Clock;

  // Single-port synchronous RAM, read-first, one-cycle read latency.
  always @(posedge Clock) begin
    if (memWe) mem[memAddr] <= memDin;
    memDout <= mem[memAddr];
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge Clock);
  endtask

  task automatic idle_inputs();
    fReq = 0; fAddr = '0; dReq = 0; dWe = 0; dAddr = '0; dWData = '0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_fGnt"},    fGnt,    0);
    chk({name, "_fValid"},  fValid,  0);
    chk({name, "_fData"},   fData,   0);
    chk({name, "_dGnt"},    dGnt,    0);
    chk({name, "_dValid"},  dValid,  0);
    chk({name, "_dRData"},  dRData,  0);
    chk({name, "_memAddr"}, memAddr, 0);
    chk({name, "_memDin"},  memDin,  0);
    chk({name, "_memWe"},   memWe,   0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
    mem[3] = 16'h1234;
    mem[7] = 16'h7777;
    memDout = '0;
    Reset = 1;
    idle_inputs();

    // Reset, then idle
    next_cycle();
    next_cycle();
    Reset = 0;
    #1 chk_all_zero("reset");
    next_cycle();
    #1 chk_all_zero("idle");

    // Single fetch at address 3
    next_cycle();
    fReq = 1; fAddr = 5'd3;
    #1 chk("f1_fGnt", fGnt, 1);
    chk("f1_memAddr", memAddr, 3);
    chk("f1_memWe", memWe, 0);
    next_cycle();
    idle_inputs();
    #1 chk("f1_fValid", fValid, 1);
    chk("f1_fData", fData, 16'h1234);
    chk("f1_fGnt_off", fGnt, 0);
    next_cycle();
    #1 chk("f1_fValid_off", fValid, 0);
    chk("f1_fData_off", fData, 0);

    // Simultaneous fetch (addr 2) and data read (addr 7)
    next_cycle();
    fReq = 1; fAddr = 5'd2; dReq = 1; dWe = 0; dAddr = 5'd7;
    #1 chk("sim_c0_dGnt", dGnt, 1);
    chk("sim_c0_fGnt", fGnt, 0);
    chk("sim_c0_memAddr", memAddr, 7);
    next_cycle();
    dReq = 0;
    #1 chk("sim_c1_fGnt", fGnt, 1);
    chk("sim_c1_memAddr", memAddr, 2);
    chk("sim_c1_dValid", dValid, 1);
    chk("sim_c1_dRData", dRData, 16'h7777);
    next_cycle();
    idle_inputs();
    #1 chk("sim_c2_fValid", fValid, 1);
    chk("sim_c2_fData", fData, 16'h1002);
    chk("sim_c2_dValid", dValid, 0);

    // Write BEEF to addr 5, then read addr 5
    next_cycle();
    dReq = 1; dWe = 1; dAddr = 5'd5; dWData = 16'hBEEF;
    #1 chk("wr_c0_dGnt", dGnt, 1);
    chk("wr_c0_memWe", memWe, 1);
    chk("wr_c0_memAddr", memAddr, 5);
    chk("wr_c0_memDin", memDin, 16'hBEEF);
    next_cycle();
    dWe = 0; dWData = '0;
    #1 chk("wr_c1_dGnt", dGnt, 0);
    chk("wr_c1_memWe", memWe, 0);
    chk("wr_c1_memAddr", memAddr, 0);
    chk("wr_c1_dValid", dValid, 1);
    chk("wr_c1_dRData", dRData, 0);
    next_cycle();
    #1 chk("wr_c2_dGnt", dGnt, 1);
    chk("wr_c2_memAddr", memAddr, 5);
    next_cycle();
    idle_inputs();
    #1 chk("wr_c3_dValid", dValid, 1);
    chk("wr_c3_dRData", dRData, 16'hBEEF);

    // Fetch held while data reads every cycle
    next_cycle();
    #1 chk("starve_pre_idle", fValid | dValid, 0);
    fetched = 0;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      fReq = !fetched; fAddr = 5'd1; dReq = 1; dWe = 0; dAddr = 5'(k + 8);
      #1 chk($sformatf("starve_k%0d_fGnt", k), fGnt, (GUARD && k == 4));
      chk($sformatf("starve_k%0d_dGnt", k), dGnt, !(GUARD && k == 4));
      if (fGnt) fetched = 1;
    end
    next_cycle();
    dReq = 0; fReq = !fetched;
    #1 chk("starve_release_fGnt", fGnt, !fetched);
    next_cycle();
    idle_inputs();
    next_cycle();

    // Back-to-back fetches at addresses 0..3
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      fReq = 1; fAddr = 5'(k);
      #1 chk($sformatf("b2b_k%0d_fGnt", k), fGnt, 1);
      chk($sformatf("b2b_k%0d_memAddr", k), memAddr, k);
      if (k == 1) begin
        chk("b2b_v0", fValid, 1);
        chk("b2b_d0", fData, 16'h1000);
      end else if (k == 2) begin
        chk("b2b_v1", fValid, 1);
        chk("b2b_d1", fData, 16'h1001);
      end else if (k == 3) begin
        chk("b2b_v2", fValid, 1);
        chk("b2b_d2", fData, 16'h1002);
      end
    end
    next_cycle();
    idle_inputs();
    #1 chk("b2b_v3", fValid, 1);
    chk("b2b_d3", fData, 16'h1234);
    next_cycle();
    #1 chk("b2b_v_off", fValid, 0);

    // Reset asserted during the response cycle of a fetch
    next_cycle();
    fReq = 1; fAddr = 5'd3;
    #1 chk("rst_mid_fGnt", fGnt, 1);
    @(posedge Clock);
    #1 Reset = 1;
    fReq = 0;
    #1 chk("rst_mid_fValid", fValid, 0);
    chk("rst_mid_fData", fData, 0);
    next_cycle();
    Reset = 0;
    #1 chk_all_zero("rst_after");
    next_cycle();
    fReq = 1; fAddr = 5'd0;
    #1 chk("rst_recover_fGnt", fGnt, 1);
    next_cycle();
    idle_inputs();
    #1 chk("rst_recover_fData", fData, 16'h1000);

    next_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
